// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-cache port arbiter.
package core_pkg;

   localparam int MAX_REQ = 8;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first masked request after last_ptr, wrapping.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int PW      = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [PW-1:0]      last_ptr,
   output logic               any,
   output logic [PW-1:0]      winner
);

   logic [NUM_REQ-1:0] cand;

   assign cand = req & mask;

   // Two passes: indices above last_ptr first, then the wrapped-around lower half.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any && cand[i] && (i > int'(last_ptr))) begin
            any    = 1'b1;
            winner = PW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any && cand[i] && (i <= int'(last_ptr))) begin
            any    = 1'b1;
            winner = PW'(i);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-cache port; one transaction in flight.
module mem_port_arbiter
   import core_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int DATA_WIDTH      = 32,
   parameter int BYTE_DATA_WIDTH = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [NUM_REQ-1:0]                 req_we,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
   input  logic [NUM_REQ*BYTE_DATA_WIDTH-1:0] req_byte_enable,
   output logic [NUM_REQ-1:0]                 req_valid,
   output logic [DATA_WIDTH-1:0]              req_rdata,
   output logic                               data_req,
   output logic [DATA_WIDTH-1:0]              data_addr,
   output logic [DATA_WIDTH-1:0]              wdata,
   output logic                               data_we,
   output logic [BYTE_DATA_WIDTH-1:0]         byte_enable,
   input  logic                               data_valid,
   input  logic [DATA_WIDTH-1:0]              rdata
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t                 state, state_nxt;
   logic [PW-1:0]              grant, last_ptr;
   logic [PW-1:0]              pick_last, pick_win;
   logic [NUM_REQ-1:0]         pick_mask;
   logic                       pick_any, load, done;
   logic                       lat_we;
   logic [DATA_WIDTH-1:0]      lat_addr, lat_wdata;
   logic [BYTE_DATA_WIDTH-1:0] lat_be;

   rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
      .req      (req),
      .mask     (pick_mask),
      .last_ptr (pick_last),
      .any      (pick_any),
      .winner   (pick_win)
   );

   assign done = (state == ARB_BUSY) && data_valid;

   // On completion the picker already sees grant as the new last_ptr so the next winner is chosen this cycle.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      pick_mask = '1;
      pick_last = last_ptr;
      req_valid = '0;
      case (state)
         ARB_IDLE: begin
            if (pick_any) begin
               load      = 1'b1;
               state_nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            pick_mask = ~(NUM_REQ'(1) << grant);
            pick_last = grant;
            if (data_valid) begin
               req_valid = NUM_REQ'(1) << grant;
               if (pick_any) load = 1'b1;
               else          state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ARB_IDLE;
         grant     <= '0;
         last_ptr  <= PW'(NUM_REQ - 1);
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
      end else begin
         state <= state_nxt;
         if (done) last_ptr <= grant;
         if (load) begin
            grant     <= pick_win;
            lat_we    <= req_we[pick_win];
            lat_addr  <= req_addr[int'(pick_win)*DATA_WIDTH +: DATA_WIDTH];
            lat_wdata <= req_wdata[int'(pick_win)*DATA_WIDTH +: DATA_WIDTH];
            lat_be    <= req_byte_enable[int'(pick_win)*BYTE_DATA_WIDTH +: BYTE_DATA_WIDTH];
         end
      end
   end

   assign data_req    = (state == ARB_BUSY);
   assign data_addr   = lat_addr;
   assign wdata       = lat_wdata;
   assign data_we     = lat_we;
   assign byte_enable = lat_be;
   assign req_rdata   = rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector table plus completion scoreboard for mem_port_arbiter (2- and 3-requester builds).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rdata;

   logic [1:0]  req2, we2, vld2;
   logic [63:0] addr2, wd2;
   logic [7:0]  be2;
   logic [31:0] rrd2, daddr2, dwd2;
   logic [3:0]  dbe2;
   logic        dreq2, dwe2, dv2;

   logic [2:0]  req3, vld3;
   logic [95:0] addr3;
   logic [31:0] rrd3, daddr3, dwd3;
   logic [3:0]  dbe3;
   logic        dreq3, dwe3, dv3;

   always #5 clk = ~clk;

   mem_port_arbiter #(.NUM_REQ(2)) u_dut2 (
      .clk(clk), .rst(rst), .req(req2), .req_we(we2), .req_addr(addr2), .req_wdata(wd2),
      .req_byte_enable(be2), .req_valid(vld2), .req_rdata(rrd2), .data_req(dreq2),
      .data_addr(daddr2), .wdata(dwd2), .data_we(dwe2), .byte_enable(dbe2),
      .data_valid(dv2), .rdata(rdata)
   );

   mem_port_arbiter #(.NUM_REQ(3)) u_dut3 (
      .clk(clk), .rst(rst), .req(req3), .req_we(3'b000), .req_addr(addr3), .req_wdata(96'h0),
      .req_byte_enable(12'h0), .req_valid(vld3), .req_rdata(rrd3), .data_req(dreq3),
      .data_addr(daddr3), .wdata(dwd3), .data_we(dwe3), .byte_enable(dbe3),
      .data_valid(dv3), .rdata(rdata)
   );

   typedef struct {
      logic [1:0]  req;
      logic        dv;
      logic [31:0] rd;
      logic        ereq;
      logic [1:0]  evld;
      logic [31:0] eaddr;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] rd;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb2[$];
   sb_t  sb3[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [1:0] r, input logic d, input logic [31:0] rd,
                      input logic er, input logic [1:0] ev, input logic [31:0] ea);
      tbl.push_back('{r, d, rd, er, ev, ea});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Completion monitors: every req_valid pulse must match the oldest expected completion.
   always @(negedge clk) begin
      if (!rst && vld2 !== 2'b00) begin
         if (sb2.size() == 0) chk("sb2_unexpected_valid", 64'(vld2), 64'h0);
         else begin
            sb_t e;
            e = sb2.pop_front();
            chk("sb2_valid", 64'(vld2), 64'(1) << e.idx);
            chk("sb2_rdata", 64'(rrd2), 64'(e.rd));
         end
      end
      if (!rst && vld3 !== 3'b000) begin
         if (sb3.size() == 0) chk("sb3_unexpected_valid", 64'(vld3), 64'h0);
         else begin
            sb_t e;
            e = sb3.pop_front();
            chk("sb3_valid", 64'(vld3), 64'(1) << e.idx);
            chk("sb3_rdata", 64'(rrd3), 64'(e.rd));
         end
      end
   end

   initial begin
      int wseq[3];
      rst = 1'b1; rdata = '0;
      req2 = '0; we2 = '0; addr2 = {32'h200, 32'h100}; wd2 = '0; be2 = '0; dv2 = 1'b0;
      req3 = '0; addr3 = {32'h1200, 32'h1100, 32'h1000}; dv3 = 1'b0;

      // Reset state, with a data_valid present to show it is ignored
      repeat (2) next_cycle();
      dv2 = 1'b1; dv3 = 1'b1;
      @(negedge clk);
      chk("rst_data_req", 64'(dreq2), 64'h0);
      chk("rst_data_we", 64'(dwe2), 64'h0);
      chk("rst_data_addr", 64'(daddr2), 64'h0);
      chk("rst_wdata", 64'(dwd2), 64'h0);
      chk("rst_byte_enable", 64'(dbe2), 64'h0);
      chk("rst_req_valid", 64'(vld2), 64'h0);
      chk("rst_req_valid3", 64'(vld3), 64'h0);
      next_cycle();
      dv2 = 1'b0; dv3 = 1'b0; rst = 1'b0;

      // Contention 0,1,0,1 -> stray data_valid in IDLE -> single read -> drop while granted
      add(2'b11, 0, 32'h0,        0, 2'b00, 32'h0);
      add(2'b11, 0, 32'h0,        1, 2'b00, 32'h100);
      add(2'b11, 1, 32'hA0,       1, 2'b01, 32'h100);
      add(2'b11, 0, 32'h0,        1, 2'b00, 32'h200);
      add(2'b11, 1, 32'hA1,       1, 2'b10, 32'h200);
      add(2'b11, 0, 32'h0,        1, 2'b00, 32'h100);
      add(2'b11, 1, 32'hA2,       1, 2'b01, 32'h100);
      add(2'b11, 0, 32'h0,        1, 2'b00, 32'h200);
      add(2'b10, 1, 32'hA3,       1, 2'b10, 32'h200);
      add(2'b00, 0, 32'h0,        0, 2'b00, 32'h200);
      add(2'b00, 1, 32'h55,       0, 2'b00, 32'h200);
      add(2'b01, 0, 32'h0,        0, 2'b00, 32'h200);
      add(2'b01, 0, 32'h0,        1, 2'b00, 32'h100);
      add(2'b01, 0, 32'h0,        1, 2'b00, 32'h100);
      add(2'b01, 0, 32'h0,        1, 2'b00, 32'h100);
      add(2'b01, 1, 32'hDEADBEEF, 1, 2'b01, 32'h100);
      add(2'b00, 0, 32'h0,        0, 2'b00, 32'h100);
      add(2'b01, 0, 32'h0,        0, 2'b00, 32'h100);
      add(2'b00, 0, 32'h0,        1, 2'b00, 32'h100);
      add(2'b00, 1, 32'h77,       1, 2'b01, 32'h100);
      add(2'b00, 0, 32'h0,        0, 2'b00, 32'h100);

      foreach (tbl[i]) begin
         req2 = tbl[i].req; dv2 = tbl[i].dv; rdata = tbl[i].rd;
         if (tbl[i].evld != 2'b00) sb2.push_back('{(tbl[i].evld == 2'b10) ? 1 : 0, tbl[i].rd});
         @(negedge clk);
         chk($sformatf("v%0d_data_req", i), 64'(dreq2), 64'(tbl[i].ereq));
         chk($sformatf("v%0d_req_valid", i), 64'(vld2), 64'(tbl[i].evld));
         chk($sformatf("v%0d_data_addr", i), 64'(daddr2), 64'(tbl[i].eaddr));
         chk($sformatf("v%0d_req_rdata", i), 64'(rrd2), 64'(tbl[i].rd));
         next_cycle();
      end
      req2 = '0; dv2 = 1'b0; rdata = '0;

      // Write held stable through a 5-cycle stall while the requester changes its inputs
      we2 = 2'b01; be2 = 8'h03; wd2 = {32'h0, 32'h1234}; req2 = 2'b01;
      next_cycle();
      we2 = 2'b00; be2 = 8'h0F; wd2 = {32'h0, 32'hFFFF};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("wr_data_req", 64'(dreq2), 64'h1);
         chk("wr_data_we", 64'(dwe2), 64'h1);
         chk("wr_byte_enable", 64'(dbe2), 64'h3);
         chk("wr_wdata", 64'(dwd2), 64'h1234);
         chk("wr_data_addr", 64'(daddr2), 64'h100);
         next_cycle();
      end
      dv2 = 1'b1; rdata = 32'hCAFE0000; sb2.push_back('{0, 32'hCAFE0000});
      next_cycle();
      dv2 = 1'b0; req2 = '0;
      @(negedge clk);
      chk("wr_idle_data_req", 64'(dreq2), 64'h0);
      next_cycle();

      // Async reset mid-BUSY, then the first win under req=11 goes to requester 0
      req2 = 2'b01;
      next_cycle();
      @(posedge clk);
      #2;
      rst = 1'b1; dv2 = 1'b1; rdata = 32'h99;
      #1;
      chk("rst_busy_data_req", 64'(dreq2), 64'h0);
      chk("rst_busy_req_valid", 64'(vld2), 64'h0);
      next_cycle();
      rst = 1'b0; dv2 = 1'b0; req2 = 2'b11;
      @(negedge clk);
      chk("post_rst_idle", 64'(dreq2), 64'h0);
      next_cycle();
      @(negedge clk);
      chk("post_rst_win0_req", 64'(dreq2), 64'h1);
      chk("post_rst_win0_addr", 64'(daddr2), 64'h100);
      next_cycle();
      dv2 = 1'b1; rdata = 32'hB0; sb2.push_back('{0, 32'hB0});
      next_cycle();
      dv2 = 1'b0; req2 = 2'b10;
      @(negedge clk);
      chk("post_rst_win1_addr", 64'(daddr2), 64'h200);
      next_cycle();
      dv2 = 1'b1; rdata = 32'hB1; sb2.push_back('{1, 32'hB1});
      next_cycle();
      dv2 = 1'b0; req2 = 2'b00;
      @(negedge clk);
      chk("post_rst_idle2", 64'(dreq2), 64'h0);
      next_cycle();

      // Wrap-around with three requesters: last_ptr=2, req=110 -> 1, 2, 1
      wseq = '{1, 2, 1};
      req3 = 3'b110;
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("wrap%0d_data_req", k), 64'(dreq3), 64'h1);
         chk($sformatf("wrap%0d_data_addr", k), 64'(daddr3), 64'h1000 + 64'(wseq[k]) * 64'h100);
         next_cycle();
         dv3 = 1'b1; rdata = 32'hA000 + 32'(wseq[k]);
         sb3.push_back('{wseq[k], 32'hA000 + 32'(wseq[k])});
         if (k == 2) req3 = 3'b000;
         next_cycle();
         dv3 = 1'b0;
      end
      @(negedge clk);
      chk("wrap_idle", 64'(dreq3), 64'h0);

      chk("sb2_drained", 64'(sb2.size()), 64'h0);
      chk("sb3_drained", 64'(sb3.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
